// File: rtl/adder_32.sv
// Purpose: registered two's-complement adder producing sum, carry and signed overflow.
// Latency: 1 cycle from in_valid to out_valid, one operation per clock.
// Backpressure: none; results are produced every cycle that in_valid is high.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   in_valid           a_in/b_in carry a valid operand pair this cycle
//   a_in, b_in         WIDTH-bit two's-complement operands
//   out_valid          sum/carry_out/overflow hold a fresh result this cycle
//   sum                (a_in + b_in) mod 2^WIDTH, or clamped when saturating
//   carry_out          unsigned carry out of the MSB of the raw addition
//   overflow           signed overflow of the raw addition
//
// Build option: define ADD_SATURATE_EN to clamp sum to the most-positive or
// most-negative value on signed overflow. The flags still report the raw addition.
module adder_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   raw_sum;
  logic             raw_ovf;
  logic [WIDTH-1:0] sum_next;

  // Zero-extend both operands so the extra bit is the unsigned carry.
  assign raw_sum = {1'b0, a_in} + {1'b0, b_in};

  // Overflow only when both operands share a sign and the result's sign differs.
  assign raw_ovf = (a_in[MSB] == b_in[MSB]) && (raw_sum[MSB] != a_in[MSB]);

`ifdef ADD_SATURATE_EN
  always_comb begin
    sum_next = raw_sum[WIDTH-1:0];
    if (raw_ovf) begin
      // Operand sign picks the rail: negative operands clamp to most-negative.
      if (a_in[MSB]) begin
        sum_next = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        sum_next = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end
  end
`else
  assign sum_next = raw_sum[WIDTH-1:0];
`endif

  // Result registers only load on in_valid, so X on idle operands never
  // reaches the held outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum       <= sum_next;
        carry_out <= raw_sum[WIDTH];
        overflow  <= raw_ovf;
      end
    end
  end

endmodule

// File: tb/tb_adder_32.sv
// Purpose: directed self-checking bench for adder_32 (WIDTH=32).
// Latency: checks each result 1 ns after the capturing rising edge.
// Backpressure: not applicable; operands are driven on falling edges.
module tb_adder_32;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  int checks;
  int errors;

  adder_32 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive a valid pair on the falling edge, then sample just after the capture edge.
  task automatic step(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    @(posedge clk);
    #1;
  endtask

  // Idle cycle with undefined operands.
  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    a_in     = 'x;
    b_in     = 'x;
    @(posedge clk);
    #1;
  endtask

  // Expected sum for a pair, including clamping when saturation is built in.
  function automatic logic [WIDTH-1:0] exp_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] full;
    logic           ovf;
    full = {1'b0, a} + {1'b0, b};
    ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    exp_sum = full[WIDTH-1:0];
`ifdef ADD_SATURATE_EN
    if (ovf) exp_sum = a[WIDTH-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
  endfunction

  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH:0]   rfull;
  logic [WIDTH-1:0] held;

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a_in     = 32'hDEAD_BEEF;
    b_in     = 32'h1234_5678;

    // 1. Reset holds outputs low even with in_valid asserted.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
    end
    check("rst_carry", carry_out, 0);
    check("rst_overflow", overflow, 0);

    @(negedge clk);
    rst_n    = 1'b1;
    a_in     = 32'h0000_0003;
    b_in     = 32'h0000_0004;
    @(posedge clk);
    #1;
    check("first_out_valid", out_valid, 1);
    check("first_sum", sum, 32'h0000_0007);

    // 2. Mixed-sign pair, then back-to-back random pairs.
    step(32'h1215_3524, 32'hC089_5E81);
    check("mix_sum", sum, 32'hD29E_93A5);
    check("mix_carry", carry_out, 0);
    check("mix_overflow", overflow, 0);
    check("mix_valid", out_valid, 1);

    for (int i = 0; i < 10; i++) begin
      ra    = $urandom;
      rb    = $urandom;
      rfull = {1'b0, ra} + {1'b0, rb};
      step(ra, rb);
      check("rand_valid", out_valid, 1);
      check("rand_sum", sum, exp_sum(ra, rb));
      check("rand_carry", carry_out, rfull[WIDTH]);
    end

    // 3. Unsigned wrap.
    step(32'hFFFF_FFFF, 32'h0000_0001);
    check("wrap_sum", sum, 32'h0000_0000);
    check("wrap_carry", carry_out, 1);
    check("wrap_overflow", overflow, 0);

    // 4. Positive overflow.
    step(32'h7FFF_FFFF, 32'h0000_0001);
`ifdef ADD_SATURATE_EN
    check("posovf_sum", sum, 32'h7FFF_FFFF);
`else
    check("posovf_sum", sum, 32'h8000_0000);
`endif
    check("posovf_carry", carry_out, 0);
    check("posovf_overflow", overflow, 1);

    // 5. Negative overflow.
    step(32'h8000_0000, 32'hFFFF_FFFF);
`ifdef ADD_SATURATE_EN
    check("negovf_sum", sum, 32'h8000_0000);
`else
    check("negovf_sum", sum, 32'h7FFF_FFFF);
`endif
    check("negovf_carry", carry_out, 1);
    check("negovf_overflow", overflow, 1);
    held = sum;

    // 6. Hold with X operands, then asynchronous mid-cycle reset.
    for (int i = 0; i < 3; i++) begin
      idle();
      check("hold_valid", out_valid, 0);
      check("hold_sum", sum, held);
      check("hold_carry", carry_out, 1);
      check("hold_overflow", overflow, 1);
    end

    // Launch an operation, then reset before its result would be used.
    step(32'h0000_1000, 32'h0000_0234);
    check("pre_rst_sum", sum, 32'h0000_1234);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sum", sum, 0);
    check("async_rst_valid", out_valid, 0);
    check("async_rst_carry", carry_out, 0);
    check("async_rst_overflow", overflow, 0);

    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_no_valid", out_valid, 0);
    check("post_rst_sum", sum, 0);

    step(32'h0000_0010, 32'h0000_0020);
    check("post_rst_fresh_valid", out_valid, 1);
    check("post_rst_fresh_sum", sum, 32'h0000_0030);

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
